jtag_dr_bank: RTL and testbench

JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

---
 rtl/jtag_dr_bank_if.sv | 39 +++
 rtl/jtag_dr_bank.sv | 131 +++++++++++++
 tb/tb_jtag_dr_bank.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dr_bank_if.sv
// Data-register side of a JTAG TAP: state strobes, instruction, serial data
// and the parallel capture/update ports of the user registers.
interface jtag_dr_bank_if #(
  parameter int INSN_WIDTH = 4,
  parameter int NUM_USER   = 2,
  parameter int DR_WIDTH   = 16
);
  logic                           tdi;
  logic                           state_test_logic_reset;
  logic                           state_capture_dr;
  logic                           state_shift_dr;
  logic                           state_update_dr;
  logic                           state_shift_ir;
  logic [INSN_WIDTH-1:0]          latched_jtag_ir;
  logic                           insn_tdo;
  logic [NUM_USER*DR_WIDTH-1:0]   capture_data;
  logic [NUM_USER*DR_WIDTH-1:0]   update_data;
  logic [NUM_USER-1:0]            update_valid;
  logic [NUM_USER-1:0]            shift_len_err;
  logic                           insn_idcode_select;
  logic [NUM_USER-1:0]            insn_user_select;
  logic                           insn_bypass_select;
  logic                           tdo;
  logic                           tdo_en;

  modport master (
    output tdi, state_test_logic_reset, state_capture_dr, state_shift_dr,
           state_update_dr, state_shift_ir, latched_jtag_ir, insn_tdo, capture_data,
    input  update_data, update_valid, shift_len_err, insn_idcode_select,
           insn_user_select, insn_bypass_select, tdo, tdo_en
  );

  modport slave (
    input  tdi, state_test_logic_reset, state_capture_dr, state_shift_dr,
           state_update_dr, state_shift_ir, latched_jtag_ir, insn_tdo, capture_data,
    output update_data, update_valid, shift_len_err, insn_idcode_select,
           insn_user_select, insn_bypass_select, tdo, tdo_en
  );
endinterface

// File: rtl/jtag_dr_bank.sv
// IDCODE, BYPASS and NUM_USER user data registers behind a JTAG TAP.
// DR state moves on posedge tck; tdo/tdo_en launch on negedge tck.
module jtag_dr_bank #(
  parameter logic [31:0]           IDCODE_VALUE   = 32'h1495_1C39,
  parameter int                    INSN_WIDTH     = 4,
  parameter logic [INSN_WIDTH-1:0] IDCODE_INSN    = 4'b0010,
  parameter int                    NUM_USER       = 2,
  parameter int                    DR_WIDTH       = 16,
  parameter logic [INSN_WIDTH-1:0] USER_INSN_BASE = 4'b1000
) (
  input logic           tck,
  input logic           trstn,
  jtag_dr_bank_if.slave bus
);

  localparam int CW = $clog2(DR_WIDTH + 2);

  logic                tlr;
  logic                cap;
  logic                shf;
  logic                upd;
  logic                idcode_sel;
  logic                bypass_sel;
  logic [NUM_USER-1:0] user_sel;
  logic [NUM_USER-1:0] user_lsb;
  logic [31:0]         idcode_reg;
  logic                bypass_reg;
  logic                tdo_mux;
  logic                tdo_reg;
  logic                tdo_en_reg;

  // One-hot view of the TAP strobes after priority resolution.
  assign tlr = bus.state_test_logic_reset;
  assign cap = !tlr && bus.state_capture_dr;
  assign shf = !tlr && !bus.state_capture_dr && bus.state_shift_dr;
  assign upd = !tlr && !bus.state_capture_dr && !bus.state_shift_dr && bus.state_update_dr;

  assign idcode_sel = (bus.latched_jtag_ir == IDCODE_INSN);
  assign bypass_sel = !idcode_sel && !(|user_sel);

  assign bus.insn_idcode_select = idcode_sel;
  assign bus.insn_user_select   = user_sel;
  assign bus.insn_bypass_select = bypass_sel;

  always_ff @(posedge tck) begin
    if (!trstn) begin
      idcode_reg <= IDCODE_VALUE;
      bypass_reg <= 1'b0;
    end else if (tlr) begin
      idcode_reg <= IDCODE_VALUE;
      bypass_reg <= 1'b0;
    end else if (cap) begin
      if (idcode_sel) idcode_reg <= IDCODE_VALUE;
      if (bypass_sel) bypass_reg <= 1'b0;
    end else if (shf) begin
      if (idcode_sel) idcode_reg <= {bus.tdi, idcode_reg[31:1]};
      if (bypass_sel) bypass_reg <= bus.tdi;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
      logic [DR_WIDTH-1:0] sr_reg;
      logic [DR_WIDTH-1:0] upd_reg;
      logic [CW-1:0]       cnt_reg;
      logic                arm_reg;
      logic                valid_reg;
      logic                err_reg;

      assign user_sel[gi] = (bus.latched_jtag_ir == INSN_WIDTH'(USER_INSN_BASE + gi));
      assign user_lsb[gi] = sr_reg[0];

      // arm_reg marks a capture since the last reset, so a session cut short
      // by trstn or Test-Logic-Reset never commits on a later Update-DR.
      always_ff @(posedge tck) begin
        if (!trstn) begin
          sr_reg    <= '0;
          upd_reg   <= '0;
          cnt_reg   <= '0;
          arm_reg   <= 1'b0;
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
        end else begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
          if (tlr) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
            arm_reg <= 1'b0;
          end else if (cap && user_sel[gi]) begin
            sr_reg  <= bus.capture_data[gi*DR_WIDTH +: DR_WIDTH];
            cnt_reg <= '0;
            arm_reg <= 1'b1;
          end else if (shf && user_sel[gi]) begin
            sr_reg <= {bus.tdi, sr_reg[DR_WIDTH-1:1]};
            if (cnt_reg != CW'(DR_WIDTH + 1)) cnt_reg <= cnt_reg + CW'(1);
          end else if (upd && user_sel[gi] && arm_reg) begin
            upd_reg   <= sr_reg;
            valid_reg <= 1'b1;
            err_reg   <= (cnt_reg != CW'(DR_WIDTH));
          end
        end
      end

      assign bus.update_data[gi*DR_WIDTH +: DR_WIDTH] = upd_reg;
      assign bus.update_valid[gi]  = valid_reg;
      assign bus.shift_len_err[gi] = err_reg;
    end
  endgenerate

  always_comb begin
    tdo_mux = bypass_reg;
    if (bus.state_shift_ir)  tdo_mux = bus.insn_tdo;
    else if (idcode_sel)     tdo_mux = idcode_reg[0];
    else if (|user_sel)      tdo_mux = |(user_sel & user_lsb);
  end

  always_ff @(negedge tck) begin
    if (!trstn) begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_mux;
      tdo_en_reg <= bus.state_shift_ir | bus.state_shift_dr;
    end
  end

  assign bus.tdo    = tdo_reg;
  assign bus.tdo_en = tdo_en_reg;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Bench for jtag_dr_bank: directed scenarios with literal expectations plus
// randomized DR sessions, all checked each cycle against a behavioural model.
module tb_jtag_dr_bank;

  localparam int W  = 16;
  localparam int NU = 2;
  localparam logic [31:0] IDV = 32'h1495_1C39;

  logic tck;
  logic trstn;
  int   checks;
  int   errors;

  jtag_dr_bank_if #(.INSN_WIDTH(4), .NUM_USER(NU), .DR_WIDTH(W)) bus ();

  jtag_dr_bank #(
    .IDCODE_VALUE(IDV), .INSN_WIDTH(4), .IDCODE_INSN(4'b0010),
    .NUM_USER(NU), .DR_WIDTH(W), .USER_INSN_BASE(4'b1000)
  ) dut (
    .tck(tck), .trstn(trstn), .bus(bus)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // Behavioural model state.
  logic [31:0]   m_id;
  logic          m_byp;
  logic [63:0]   m_sr  [NU];
  int            m_cnt [NU];
  bit            m_arm [NU];
  logic [63:0]   m_upd [NU];
  logic [NU-1:0] m_valid;
  logic [NU-1:0] m_err;

  logic            last_tdo;
  logic            last_tdo_en;
  logic [NU-1:0]   last_valid;
  logic [NU-1:0]   last_err;
  logic [NU*W-1:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NU-1:0] user_decode(input logic [3:0] ir);
    logic [NU-1:0] s;
    for (int i = 0; i < NU; i++) s[i] = (int'(ir) == 8 + i);
    return s;
  endfunction

  task automatic model_edge(input bit rn, input bit tl, input bit cp, input bit sd,
                            input bit ud, input bit ti, input logic [3:0] ir);
    logic [NU-1:0] us;
    bit ids, bys;
    us  = user_decode(ir);
    ids = (ir == 4'b0010);
    bys = !ids && (us == '0);
    m_valid = '0;
    m_err   = '0;
    if (!rn || tl) begin
      m_id  = IDV;
      m_byp = 1'b0;
      for (int i = 0; i < NU; i++) begin
        m_sr[i] = '0; m_cnt[i] = 0; m_arm[i] = 0;
        if (!rn) m_upd[i] = '0;
      end
    end else if (cp) begin
      if (ids) m_id = IDV;
      if (bys) m_byp = 1'b0;
      for (int i = 0; i < NU; i++)
        if (us[i]) begin
          m_sr[i] = 64'(bus.capture_data[i*W +: W]); m_cnt[i] = 0; m_arm[i] = 1;
        end
    end else if (sd) begin
      if (ids) m_id = (m_id >> 1) | (32'(ti) << 31);
      if (bys) m_byp = ti;
      for (int i = 0; i < NU; i++)
        if (us[i]) begin
          m_sr[i]  = (m_sr[i] >> 1) | (64'(ti) << (W - 1));
          m_cnt[i] = (m_cnt[i] >= W + 1) ? W + 1 : m_cnt[i] + 1;
        end
    end else if (ud) begin
      for (int i = 0; i < NU; i++)
        if (us[i] && m_arm[i]) begin
          m_upd[i]   = m_sr[i];
          m_valid[i] = 1'b1;
          m_err[i]   = (m_cnt[i] != W);
        end
    end
  endtask

  // One TCK cycle: drive inputs, advance the model at posedge, compare the
  // posedge outputs at +1, then compare the negedge-launched tdo at +1.
  task automatic cycle(input bit rn, input bit tl, input bit cp, input bit sd,
                       input bit ud, input bit si, input bit ti, input bit it);
    logic [NU*W-1:0] exp_data;
    logic [NU-1:0]   us;
    logic            exp_tdo;
    trstn = rn;
    bus.state_test_logic_reset = tl;
    bus.state_capture_dr = cp;
    bus.state_shift_dr   = sd;
    bus.state_update_dr  = ud;
    bus.state_shift_ir   = si;
    bus.tdi      = ti;
    bus.insn_tdo = it;
    @(posedge tck);
    model_edge(rn, tl, cp, sd, ud, ti, bus.latched_jtag_ir);
    #1;
    for (int i = 0; i < NU; i++) exp_data[i*W +: W] = m_upd[i][W-1:0];
    us = user_decode(bus.latched_jtag_ir);
    chk("update_data", bus.update_data, exp_data);
    chk("update_valid", bus.update_valid, m_valid);
    chk("shift_len_err", bus.shift_len_err, m_err);
    chk("idcode_select", bus.insn_idcode_select, bus.latched_jtag_ir == 4'b0010);
    chk("user_select", bus.insn_user_select, us);
    chk("bypass_select", bus.insn_bypass_select, (bus.latched_jtag_ir != 4'b0010) && (us == '0));
    last_valid = bus.update_valid;
    last_err   = bus.shift_len_err;
    last_data  = bus.update_data;
    @(negedge tck);
    if (!rn) exp_tdo = 1'b0;
    else if (si) exp_tdo = it;
    else if (bus.latched_jtag_ir == 4'b0010) exp_tdo = m_id[0];
    else if (us != '0) begin
      exp_tdo = 1'b0;
      for (int i = 0; i < NU; i++) if (us[i]) exp_tdo = m_sr[i][0];
    end else exp_tdo = m_byp;
    #1;
    chk("tdo", bus.tdo, exp_tdo);
    chk("tdo_en", bus.tdo_en, rn && (si || sd));
    last_tdo    = bus.tdo;
    last_tdo_en = bus.tdo_en;
  endtask

  task automatic session(input logic [3:0] ir, input int n, input logic [63:0] din,
                         input bit upd, input bit cap_shift, input bit noise,
                         output logic [63:0] stream);
    bus.latched_jtag_ir = ir;
    stream = '0;
    cycle(1, 0, 1, cap_shift, 0, 0, 0, 0);
    stream[0] = last_tdo;
    for (int k = 1; k <= n; k++) begin
      if (noise && $urandom_range(0, 39) == 0)
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        cycle(1, 0, 0, 1, 0, 0, din[k-1], 0);
      if (k < 64) stream[k] = last_tdo;
    end
    if (upd) cycle(1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] st;
    logic [3:0]  ir;
    int          n;
    checks = 0;
    errors = 0;
    bus.latched_jtag_ir = 4'b0000;
    bus.capture_data    = '0;

    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_update_data", last_data, 0);
    chk("reset_update_valid", last_valid, 0);
    chk("reset_tdo", last_tdo, 0);
    chk("reset_tdo_en", last_tdo_en, 0);
    $display("reset: update_data=%h tdo=%b", last_data, last_tdo);

    session(4'b0010, 32, 64'd0, 0, 0, 0, st);
    chk("idcode_stream", st[31:0], 32'h1495_1C39);
    chk("idcode_tdo_en", last_tdo_en, 1);
    $display("idcode: stream=%h", st[31:0]);

    bus.capture_data = {16'h0000, 16'hA5C3};
    session(4'b1000, 16, 64'h1234, 1, 0, 0, st);
    chk("user0_stream", st[15:0], 16'hA5C3);
    chk("user0_data", last_data[15:0], 16'h1234);
    chk("user0_valid", last_valid, 2'b01);
    chk("user0_err", last_err, 2'b00);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("user0_valid_pulse_end", last_valid, 2'b00);
    $display("user0 16 shifts: stream=%h data=%h", st[15:0], last_data[15:0]);

    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    chk("tlr_keeps_update_data", last_data[15:0], 16'h1234);

    session(4'b1000, 15, 64'h1234, 1, 0, 0, st);
    chk("short_valid", last_valid, 2'b01);
    chk("short_err", last_err, 2'b01);
    chk("short_data", last_data[15:0], 16'h2469);
    $display("user0 15 shifts: data=%h err=%b", last_data[15:0], last_err);

    session(4'b0101, 3, 64'b101, 0, 0, 0, st);
    chk("bypass_select", bus.insn_bypass_select, 1);
    chk("bypass_stream", st[2:0], 3'b010);
    $display("bypass: stream=%b", st[2:0]);

    session(4'b1001, 8, 64'hC3, 0, 0, 0, st);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    chk("abort_valid", last_valid, 2'b00);
    chk("abort_data", last_data, 0);
    $display("abort: valid=%b data=%h", last_valid, last_data);

    bus.capture_data = {16'hFFFF, 16'h5A0F};
    session(4'b1000, 16, 64'd0, 1, 1, 0, st);
    chk("cap_wins_stream", st[15:0], 16'h5A0F);
    chk("cap_wins_valid", last_valid, 2'b01);
    chk("cap_wins_err", last_err, 2'b00);
    $display("capture+shift: stream=%h err=%b", st[15:0], last_err);

    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 5))
        0: ir = 4'b0010;
        1: ir = 4'b1000;
        2: ir = 4'b1001;
        3: ir = 4'b0101;
        4: ir = 4'b1111;
        default: ir = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 5))
        0: n = W - 1;
        1: n = W;
        2: n = W + 1;
        3: n = W + 4;
        4: n = 32;
        default: n = $urandom_range(0, 40);
      endcase
      bus.capture_data = {16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 9) == 0) cycle(1, 1, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 24) == 0) cycle(0, 0, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 4) == 0) cycle(1, 0, 0, 0, 0, 1, 0, 1'($urandom_range(0, 1)));
      session(ir, n, {$urandom, $urandom}, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 1, st);
      $display("session %0d ir=%h n=%0d valid=%b err=%b", s, ir, n, last_valid, last_err);
    end

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
